rr_mux_4x1: RTL



---
 rtl/rr_mux_pkg.sv | 19 +
 rtl/rr_arbiter_4.sv | 44 ++++
 rtl/rr_mux_4x1.sv | 84 ++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants for the 4-channel round-robin link (mux and demux sides).
package rr_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'b00;
    localparam logic [SEL_W-1:0] CH_B = 2'b01;
    localparam logic [SEL_W-1:0] CH_C = 2'b10;
    localparam logic [SEL_W-1:0] CH_D = 2'b11;

    // Pointer at D after reset gives A top priority.
    localparam logic [SEL_W-1:0] LAST_RST = CH_D;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: last-grant pointer plus rotating priority scan.
module rr_arbiter_4
    import rr_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] last_d;
    logic [SEL_W-1:0] cand;
    logic             found;

    // Scan last+1 .. last+4 (mod 4); first requester wins.
    always_comb begin
        grant_idx = last_q;
        found     = 1'b0;
        cand      = last_q;
        if (enable) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                cand = last_q + SEL_W'(i);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant  = found ? onehot(grant_idx) : '0;
        last_d = found ? grant_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rr_mux_4x1.sv
// Four-source round-robin mux with a single registered valid/ready output.
module rr_mux_4x1
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [WIDTH-1:0]  data_a,
    input  logic [WIDTH-1:0]  data_b,
    input  logic [WIDTH-1:0]  data_c,
    input  logic [WIDTH-1:0]  data_d,
    output logic [NUM_CH-1:0] ack,
    output logic [WIDTH-1:0]  out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic              load;
    logic              arb_en;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  gnt_data;

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;

    assign load = !out_valid_q || out_ready;
    // Gating with rst_n keeps ack low for the whole reset window.
    assign arb_en = load && rst_n;

    rr_arbiter_4 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        gnt_data = data_a;
        unique case (grant_idx)
            CH_A: gnt_data = data_a;
            CH_B: gnt_data = data_b;
            CH_C: gnt_data = data_c;
            CH_D: gnt_data = data_d;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (|grant) begin
            out_data_d  = gnt_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= CH_A;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ack       = grant;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
